// File: rtl/song_fetch_pkg.sv
// Shared types and constants for the song sample fetcher.
// The sequencer state set and the SRAM word address width live here.
package song_fetch_pkg;
    localparam int ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_L  = 3'd1,
        READ_R  = 3'd2,
        COMMIT  = 3'd3,
        STOPPED = 3'd4
    } state_t;
endpackage

// File: rtl/req_sync_edge.sv
// Brings an asynchronous strobe into the clk domain and emits a one-cycle
// pulse per rising edge. The output is registered, so the pulse appears three edges after the strobe rises.
module req_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);
    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_pulse <= r_s2 & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/song_sample_fetcher.sv
// Fetches one stereo sample (left word, then right word) from SRAM per codec
// request and holds it on LDATA/RDATA. Also manages song end, restart and underrun flagging.
module song_sample_fetcher
    import song_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR  = 20'h00000,
    parameter logic [ADDR_W-1:0] END_ADDR    = 20'hFFFFF,
    parameter int                WAIT_CYCLES = 2,
    parameter bit                LOOP        = 1'b1
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              play_en,
    input  logic              restart,
    input  logic              adc_full,
    input  logic [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [15:0]       LDATA,
    output logic [15:0]       RDATA,
    output logic              sample_valid,
    output logic              song_done,
    output logic              underrun
);
    localparam int                CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]     WAIT_LAST = CW'(WAIT_CYCLES);
    // Left address of the final pair; comparing against it avoids overflow at 20'hFFFFF.
    localparam logic [ADDR_W-1:0] LAST_L    = END_ADDR - ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_wait;
    logic [15:0]       r_lbuf;
    logic [15:0]       r_ldata;
    logic [15:0]       r_rdata;
    logic              r_valid;
    logic              r_done;
    logic              r_underrun;

    logic w_req;
    logic w_last;
    logic w_busy;
    logic w_rd;

    req_sync_edge u_req_sync (
        .clk     (clk),
        .rst_n   (Reset_n),
        .i_async (adc_full),
        .o_pulse (w_req)
    );

    assign w_last = (r_wait == WAIT_LAST);
    assign w_rd   = (r_state == READ_L) || (r_state == READ_R);
    assign w_busy = w_rd || (r_state == COMMIT);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_addr     <= START_ADDR;
            r_wait     <= '0;
            r_lbuf     <= '0;
            r_ldata    <= '0;
            r_rdata    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (restart) begin
                r_state    <= IDLE;
                r_addr     <= START_ADDR;
                r_wait     <= '0;
                r_done     <= 1'b0;
                r_underrun <= 1'b0;
            end else begin
                if (w_req && w_busy) r_underrun <= 1'b1;
                case (r_state)
                    IDLE: begin
                        if (w_req && play_en && !r_done) begin
                            r_wait  <= '0;
                            r_state <= READ_L;
                        end
                    end
                    READ_L: begin
                        if (w_last) begin
                            r_lbuf  <= SRAM_DQ;
                            r_wait  <= '0;
                            r_state <= READ_R;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                    READ_R: begin
                        // Outputs load on the edge into COMMIT so the valid pulse and the new pair coincide.
                        if (w_last) begin
                            r_ldata <= r_lbuf;
                            r_rdata <= SRAM_DQ;
                            r_valid <= 1'b1;
                            r_wait  <= '0;
                            r_state <= COMMIT;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                    COMMIT: begin
                        if (r_addr == LAST_L) begin
                            if (LOOP) begin
                                r_addr  <= START_ADDR;
                                r_state <= IDLE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= STOPPED;
                            end
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(2);
                            r_state <= IDLE;
                        end
                    end
                    STOPPED: begin
                        r_state <= STOPPED;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign SRAM_ADDR    = (r_state == READ_R) ? (r_addr + ADDR_W'(1)) : r_addr;
    assign SRAM_CE_N    = ~w_rd;
    assign SRAM_OE_N    = ~w_rd;
    assign SRAM_WE_N    = 1'b1;
    assign SRAM_UB_N    = 1'b0;
    assign SRAM_LB_N    = 1'b0;
    assign LDATA        = r_ldata;
    assign RDATA        = r_rdata;
    assign sample_valid = r_valid;
    assign song_done    = r_done;
    assign underrun     = r_underrun;
endmodule
